// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, byte-lane data memory between the instruction-fetch
// requester and the load/store requester. Data wins arbitration, but after
// MAX_STREAK consecutive data grants with fetch waiting, fetch is forced through.
// Each accepted access runs IDLE -> ACCESS (LATENCY cycles) -> RESP (done pulse).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   if_req/if_addr    fetch request and byte address (held until if_gnt)
//   if_gnt            fetch accepted (combinational, IDLE only)
//   if_done/if_rdata  one-cycle completion pulse, fetched word {lane0..lane3}
//   d_req/d_we        data request, 1 = store / 0 = load (held until d_gnt)
//   d_addr/d_wdata    data byte address and store bytes, lanes [0:3]
//   d_gnt             data accepted (combinational, IDLE only)
//   d_done/d_rdata    one-cycle completion pulse, load bytes, lanes [0:3]
//   halted            core halted; no new grants while high
//   mem_addr          word address to memory (bits [1:0] zero), 0 outside ACCESS
//   mem_data_in       store bytes to memory, 0 outside ACCESS
//   mem_data_out      read bytes from memory
//   mem_write_en      single-cycle write strobe on the last ACCESS cycle
//   busy              high in ACCESS or RESP
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LATENCY    = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [7:0]  d_wdata [4],
    output logic        d_gnt,
    output logic        d_done,
    output logic [7:0]  d_rdata [4],
    input  logic        halted,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [4],
    input  logic [7:0]  mem_data_out [4],
    output logic        mem_write_en,
    output logic        busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STK_W = $clog2(MAX_STREAK + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LATENCY - 1);
    localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(MAX_STREAK);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    state_t           state_q,  state_d;
    owner_t           owner_q,  owner_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [STK_W-1:0] streak_q, streak_d;
    logic [31:0]      addr_q,   addr_d;
    logic             we_q,     we_d;
    logic [7:0]       wdata_q   [4];
    logic [7:0]       wdata_d   [4];
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [7:0]       d_rdata_q [4];
    logic [7:0]       d_rdata_d [4];

    logic grant_data;
    logic grant_fetch;

    // Grant decision; rst gates it so every output is 0 while reset is held.
    always_comb begin
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        if (state_q == S_IDLE && !halted && !rst) begin
            grant_data  = d_req && (!if_req || (streak_q < STREAK_MAX));
            grant_fetch = if_req && !grant_data;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        streak_d     = streak_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '{default: '0};
        mem_write_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_data || grant_fetch) begin
                    wdata_d = d_wdata;
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
                if (grant_data) begin
                    d_gnt   = 1'b1;
                    addr_d  = {d_addr[31:2], 2'b00};
                    we_d    = d_we;
                    owner_d = OWN_DATA;
                    // With fetch waiting, data only wins while streak < MAX,
                    // so the increment can never pass the limit.
                    streak_d = if_req ? streak_q + STK_W'(1) : '0;
                end else if (grant_fetch) begin
                    if_gnt   = 1'b1;
                    addr_d   = {if_addr[31:2], 2'b00};
                    we_d     = 1'b0;
                    owner_d  = OWN_FETCH;
                    streak_d = '0;
                end
            end

            S_ACCESS: begin
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    mem_write_en = we_q;
                    cnt_d        = '0;
                    state_d      = S_RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_DATA) begin
                            d_rdata_d = mem_data_out;
                        end else begin
                            if_rdata_d = {mem_data_out[0], mem_data_out[1],
                                          mem_data_out[2], mem_data_out[3]};
                        end
                    end
                end
            end

            S_RESP: begin
                if (owner_q == OWN_DATA) begin
                    d_done = 1'b1;
                end else begin
                    if_done = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    // The read-data registers are reset as well: software-visible outputs must
    // read 0 after reset, not whatever the last transaction left behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_FETCH;
            cnt_q      <= '0;
            streak_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '{default: '0};
            if_rdata_q <= '0;
            d_rdata_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != S_IDLE);

endmodule
